// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the Wishbone grant scheduler.
package wb_sched_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CTI_W = 3;
    localparam int unsigned TMO_W = 8;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ABORT = 2'd3
    } sched_state_e;

    // A beat closes the owner's transfer when it is classic or end-of-burst.
    function automatic logic cti_ends_burst(input logic [CTI_W-1:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin requester pick: first unmasked request after 'last', wrapping.
module wb_rr_pick
    import wb_sched_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [NREQ-1:0]  elig;
    logic [IDX_W-1:0] cand;

    assign elig = req & ~mask;

    // Walk offsets from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        idx  = last;
        any  = 1'b0;
        cand = last;
        for (int off = NREQ; off >= 1; off--) begin
            cand = last + IDX_W'(off);
            if (elig[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_grant_sched.sv
// Wishbone bus grant scheduler: round-robin ownership with beat quota,
// burst-safe preemption and stalled-slave timeout abort.
module wb_grant_sched
    import wb_sched_pkg::*;
#(
    parameter int unsigned QUOTA   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rstn_i,
    input  logic [NREQ-1:0]   req_cyc_i,
    input  logic              own_stb_i,
    input  logic [CTI_W-1:0]  own_cti_i,
    input  logic              own_ack_i,
    output logic [IDX_W-1:0]  owner_o,
    output logic              owner_vld_o,
    output logic              bus_cyc_o,
    output logic              own_err_o,
    output logic [TMO_W-1:0]  tmo_cnt_o
);

    localparam int unsigned BEAT_W = $clog2(QUOTA + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(QUOTA);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = '1;

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [NREQ-1:0]   mask_q, mask_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [NREQ-1:0]   owner_oh;
    logic [NREQ-1:0]   others;
    logic              own_cyc;
    logic              wait_inc;
    logic              tmo_hit;
    logic              drain_rel;
    logic [BEAT_W-1:0] beat_nxt;
    logic              regrant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    // Next owner candidate, searched from the current owner onward.
    wb_rr_pick u_pick (
        .req  (req_cyc_i),
        .mask (mask_q),
        .last (owner_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign owner_oh  = NREQ'(1) << owner_q;
    assign own_cyc   = req_cyc_i[owner_q];
    assign others    = req_cyc_i & ~mask_q & ~owner_oh;
    assign wait_inc  = own_stb_i & ~own_ack_i;
    assign tmo_hit   = wait_inc & (wait_q == WAIT_LAST);
    assign drain_rel = ~own_stb_i | (own_ack_i & cti_ends_burst(own_cti_i));
    assign beat_nxt  = (own_ack_i && (beat_q != BEAT_MAX)) ? beat_q + BEAT_W'(1) : beat_q;

    // State register and counters.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            mask_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state: owner release beats timeout, timeout beats quota preemption.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        wait_d  = '0;
        mask_d  = mask_q & req_cyc_i;
        tmo_d   = tmo_q;
        regrant = 1'b0;

        case (state_q)
            ST_IDLE, ST_ABORT: regrant = 1'b1;
            ST_OWN, ST_DRAIN: begin
                beat_d = beat_nxt;
                wait_d = wait_inc ? wait_q + WAIT_W'(1) : '0;
                if (!own_cyc || ((state_q == ST_DRAIN) && drain_rel)) begin
                    regrant = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_ABORT;
                    wait_d  = '0;
                    mask_d  = (mask_q & req_cyc_i) | owner_oh;
                    if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end else if ((state_q == ST_OWN) && (beat_nxt == BEAT_MAX) && (|others)) begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (regrant) begin
            wait_d = '0;
            if (pick_any) begin
                state_d = ST_OWN;
                owner_d = pick_idx;
                beat_d  = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Output decode from the state register.
    assign owner_o     = owner_q;
    assign owner_vld_o = (state_q == ST_OWN) || (state_q == ST_DRAIN);
    assign bus_cyc_o   = owner_vld_o & own_cyc;
    assign own_err_o   = (state_q == ST_ABORT);
    assign tmo_cnt_o   = tmo_q;

endmodule
